projectile_controller: RTL and testbench
========================================

# projectile_controller

Owns one projectile: launches it from a given coordinate, advances it one step per movement tick, and retires it on a hit or when it leaves the screen. It drives the projectile coordinates that `collision_detection` checks and consumes that block's `collision` flag. Upstream, the player or alien fire logic requests shots. Downstream, score and lives logic consume the `hit` and `miss` pulses.

## Interface
- `SCREEN_H`, default 480: playfield height in pixels.
- `PROJ_H`, default 8: projectile sprite height in pixels.
- `PROJ_SPEED`, default 4: pixels moved per `clk_proj` tick.
- `DIR`, default 0: travel direction; 0 = up (decreasing y, player shot), 1 = down (alien shot).
- `COOLDOWN`, default 8: `clk_proj` ticks spent in COOLDOWN before the next fire is accepted; range 1..255.
- `clk` input 1: system clock; every register updates on the rising edge.
- `rst` input 1: asynchronous, active-low reset. Low forces all state and outputs to their reset values immediately, with no clock edge.
- `clk_proj` input 1: single-cycle movement tick enable, synchronous to `clk`.
- `fire` input 1: launch request; level sampled each cycle.
- `launch_x` input 10: launch x coordinate; upper-left corner of the sprite.
- `launch_y` input 10: launch y coordinate; upper-left corner of the sprite.
- `collision` input 1: hit flag from `collision_detection` for the current `proj_x`/`proj_y`.
- `proj_x` output 10: current projectile x.
- `proj_y` output 10: current projectile y.
- `proj_active` output 1: high while the projectile is in flight; the renderer draws it only when high.
- `ready` output 1: high only in IDLE; a `fire` is accepted only when `ready` is high.
- `hit` output 1: one-`clk` pulse when the projectile is retired by a collision.
- `miss` output 1: one-`clk` pulse when the projectile is retired by leaving the screen.

## Operation
- The FSM has three states: IDLE, FLIGHT, COOLDOWN. Reset state is IDLE.
- Reset values: `proj_x`=0, `proj_y`=0, `proj_active`=0, `ready`=1, `hit`=0, `miss`=0, cooldown counter=0.
- **IDLE:**
  - `fire`=1 latches `launch_x`/`launch_y` into `proj_x`/`proj_y`, sets `proj_active`=1, and moves to FLIGHT.
  - `clk_proj` and `collision` are ignored in IDLE.
- **FLIGHT**, evaluated each cycle in this priority order:
  - `collision`=1 (any cycle, tick or not): pulse `hit`, set `proj_active`=0, load cooldown counter = `COOLDOWN`, go to COOLDOWN. No move happens in that cycle, even if `clk_proj` is also high.
  - Else, if `clk_proj`=1 and the next position is off-screen: pulse `miss`, set `proj_active`=0, load the cooldown counter, go to COOLDOWN.
    - DIR=0: off-screen when `proj_y` < `PROJ_SPEED`.
    - DIR=1: off-screen when `proj_y` + `PROJ_SPEED` > `SCREEN_H` − `PROJ_H`. Compute this sum at 11 bits so it cannot wrap.
  - Else, if `clk_proj`=1: `proj_y` ← `proj_y` ∓ `PROJ_SPEED`. `proj_x` never changes in flight.
- **COOLDOWN:**
  - Each `clk_proj` decrements the counter. When the counter reaches 0, go to IDLE.
  - `proj_x`/`proj_y` hold their last values.
- `fire` outside IDLE is dropped. It is not queued, and `launch_x`/`launch_y` are not sampled.
- `collision` outside FLIGHT is ignored and produces no pulse.
- `hit` and `miss` are never high in the same cycle.

## Timing
- Fire latency: `fire` high at edge N gives `proj_active`=1, `ready`=0, and the launch coordinates on `proj_x`/`proj_y` after edge N.
- Move latency: a `clk_proj` at edge N updates `proj_y` after edge N.
- Hit latency: `collision` high at edge N gives `hit`=1 and `proj_active`=0 after edge N; `hit` returns to 0 after edge N+1.
- Cooldown length: exactly `COOLDOWN` `clk_proj` ticks. `ready` rises in the cycle after the final decrement.
- All outputs are registered. None is combinational from an input.
- `rst` low mid-flight or mid-cooldown: asynchronous return to IDLE with reset values. An in-progress `hit` or `miss` pulse is cleared.
- `rst` deassertion is sampled by `clk`. The first `fire` is accepted at the first edge with `rst` high.

## Test plan
- Parameters for all scenarios: DIR=0, `PROJ_SPEED`=4, `COOLDOWN`=2.
- Launch and move: in IDLE, `fire`=1 with launch (100,400) → next cycle `proj_active`=1, `ready`=0, (100,400). After 3 `clk_proj` ticks, `proj_y`=388 and `proj_x`=100.
- Hit with cooldown: `collision`=1 for one cycle at `proj_y`=388 → `hit` pulses for exactly one cycle, `proj_active`=0, `proj_y` holds 388. After 2 ticks `ready`=1; after 1 tick `ready` is still 0.
- Top-edge miss: launch y=6 → one tick gives `proj_y`=2. The next tick gives a one-cycle `miss` pulse and `proj_active`=0; `proj_y` stays 2 and does not wrap to 1022.
- Collision on a tick cycle: `collision` and `clk_proj` both high with `proj_y`=200 → `hit` pulses and `proj_y` stays 200.
- Fire while busy: `fire` with launch (300,50) during FLIGHT and during COOLDOWN → no state change, `proj_x`/`proj_y` unchanged, no pulse.
- Asynchronous reset mid-flight: drive `rst` low between clock edges at `proj_y`=300 → all outputs reach reset values before the next edge. Release `rst`, then `fire` → normal launch.

Source files
------------

// File: rtl/projectile_controller.sv
// rtl/projectile_controller.sv - single-projectile launch/flight/cooldown controller
// Drives the projectile coordinates and reports hit/miss retirement pulses.
module projectile_controller #(
  parameter int SCREEN_H   = 480,
  parameter int PROJ_H     = 8,
  parameter int PROJ_SPEED = 4,
  parameter int DIR        = 0,
  parameter int COOLDOWN   = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clk_proj,
  input  logic       fire,
  input  logic [9:0] launch_x,
  input  logic [9:0] launch_y,
  input  logic       collision,
  output logic [9:0] proj_x,
  output logic [9:0] proj_y,
  output logic       proj_active,
  output logic       ready,
  output logic       hit,
  output logic       miss
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FLIGHT,
    S_COOLDOWN
  } state_t;

  localparam logic [9:0]  SPEED   = 10'(PROJ_SPEED);
  localparam logic [10:0] Y_LIMIT = 11'(SCREEN_H - PROJ_H);
  localparam logic [7:0]  CD_LOAD = 8'(COOLDOWN);

  state_t      state, state_n;
  logic [7:0]  cd_cnt, cd_cnt_n;
  logic [9:0]  x_n, y_n;
  logic        active_n, ready_n, hit_n, miss_n;
  logic [10:0] y_sum;
  logic        off_screen;

  // Downward sum is carried at 11 bits so a sprite near the bottom cannot wrap.
  assign y_sum      = {1'b0, proj_y} + {1'b0, SPEED};
  assign off_screen = (DIR == 0) ? (proj_y < SPEED) : (y_sum > Y_LIMIT);

  always_comb begin
    state_n  = state;
    cd_cnt_n = cd_cnt;
    x_n      = proj_x;
    y_n      = proj_y;
    active_n = proj_active;
    hit_n    = 1'b0;
    miss_n   = 1'b0;
    case (state)
      S_IDLE: begin
        if (fire) begin
          x_n      = launch_x;
          y_n      = launch_y;
          active_n = 1'b1;
          state_n  = S_FLIGHT;
        end
      end
      S_FLIGHT: begin
        // Collision wins over a coincident movement tick.
        if (collision) begin
          hit_n    = 1'b1;
          active_n = 1'b0;
          cd_cnt_n = CD_LOAD;
          state_n  = S_COOLDOWN;
        end else if (clk_proj) begin
          if (off_screen) begin
            miss_n   = 1'b1;
            active_n = 1'b0;
            cd_cnt_n = CD_LOAD;
            state_n  = S_COOLDOWN;
          end else if (DIR == 0) begin
            y_n = proj_y - SPEED;
          end else begin
            y_n = proj_y + SPEED;
          end
        end
      end
      S_COOLDOWN: begin
        if (clk_proj) begin
          if (cd_cnt <= 8'd1) begin
            cd_cnt_n = 8'd0;
            state_n  = S_IDLE;
          end else begin
            cd_cnt_n = cd_cnt - 8'd1;
          end
        end
      end
      default: begin
        state_n  = S_IDLE;
        cd_cnt_n = 8'd0;
        active_n = 1'b0;
      end
    endcase
    ready_n = (state_n == S_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      cd_cnt      <= 8'd0;
      proj_x      <= 10'd0;
      proj_y      <= 10'd0;
      proj_active <= 1'b0;
      ready       <= 1'b1;
      hit         <= 1'b0;
      miss        <= 1'b0;
    end else begin
      state       <= state_n;
      cd_cnt      <= cd_cnt_n;
      proj_x      <= x_n;
      proj_y      <= y_n;
      proj_active <= active_n;
      ready       <= ready_n;
      hit         <= hit_n;
      miss        <= miss_n;
    end
  end

endmodule

// File: tb/tb_projectile_controller.sv
// tb/tb_projectile_controller.sv - directed self-checking bench for projectile_controller
// DIR=0, PROJ_SPEED=4, COOLDOWN=2; expected values are hand-computed.
module tb_projectile_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clk_proj = 1'b0;
  logic       fire = 1'b0;
  logic [9:0] launch_x = '0;
  logic [9:0] launch_y = '0;
  logic       collision = 1'b0;
  logic [9:0] proj_x, proj_y;
  logic       proj_active, ready, hit, miss;

  int checks = 0;
  int errors = 0;

  projectile_controller #(
    .SCREEN_H(480), .PROJ_H(8), .PROJ_SPEED(4), .DIR(0), .COOLDOWN(2)
  ) dut (
    .clk(clk), .rst(rst), .clk_proj(clk_proj), .fire(fire),
    .launch_x(launch_x), .launch_y(launch_y), .collision(collision),
    .proj_x(proj_x), .proj_y(proj_y), .proj_active(proj_active),
    .ready(ready), .hit(hit), .miss(miss)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Apply one cycle of inputs, then sample 1ns after the rising edge.
  task automatic step(input logic f, input logic t, input logic c,
                      input logic [9:0] lx, input logic [9:0] ly);
    fire = f; clk_proj = t; collision = c; launch_x = lx; launch_y = ly;
    @(posedge clk);
    #1;
    fire = 1'b0; clk_proj = 1'b0; collision = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_x"}, 32'(proj_x), 32'd0);
    check({tag, "_y"}, 32'(proj_y), 32'd0);
    check({tag, "_active"}, 32'(proj_active), 32'd0);
    check({tag, "_ready"}, 32'(ready), 32'd1);
    check({tag, "_hit"}, 32'(hit), 32'd0);
    check({tag, "_miss"}, 32'(miss), 32'd0);
  endtask

  initial begin
    #1 rst = 1'b0;
    #1 check_reset_vals("rst0");
    @(posedge clk); #1;
    rst = 1'b1;

    // Launch and move
    step(1, 0, 0, 10'd100, 10'd400);
    check("launch_active", 32'(proj_active), 32'd1);
    check("launch_ready", 32'(ready), 32'd0);
    check("launch_x", 32'(proj_x), 32'd100);
    check("launch_y", 32'(proj_y), 32'd400);
    step(0, 1, 0, 10'd0, 10'd0);
    check("move1_y", 32'(proj_y), 32'd396);
    step(0, 0, 0, 10'd0, 10'd0);
    check("notick_y", 32'(proj_y), 32'd396);
    step(0, 1, 0, 10'd0, 10'd0);
    step(0, 1, 0, 10'd0, 10'd0);
    check("move3_y", 32'(proj_y), 32'd388);
    check("move3_x", 32'(proj_x), 32'd100);

    // Hit with cooldown, plus fire/collision dropped during cooldown
    step(0, 0, 1, 10'd0, 10'd0);
    check("hit_pulse", 32'(hit), 32'd1);
    check("hit_nomiss", 32'(miss), 32'd0);
    check("hit_active", 32'(proj_active), 32'd0);
    check("hit_y", 32'(proj_y), 32'd388);
    step(1, 0, 1, 10'd300, 10'd50);
    check("hit_end", 32'(hit), 32'd0);
    check("cdfire_x", 32'(proj_x), 32'd100);
    check("cdfire_y", 32'(proj_y), 32'd388);
    check("cdfire_ready", 32'(ready), 32'd0);
    check("cdfire_active", 32'(proj_active), 32'd0);
    step(0, 1, 0, 10'd0, 10'd0);
    check("cd1_ready", 32'(ready), 32'd0);
    step(0, 0, 0, 10'd0, 10'd0);
    check("cd1_hold_ready", 32'(ready), 32'd0);
    step(0, 1, 0, 10'd0, 10'd0);
    check("cd2_ready", 32'(ready), 32'd1);
    check("cd2_y", 32'(proj_y), 32'd388);

    // Top-edge miss, with fire dropped during flight
    step(1, 0, 0, 10'd10, 10'd6);
    check("edge_launch_y", 32'(proj_y), 32'd6);
    step(0, 1, 0, 10'd0, 10'd0);
    check("edge_move_y", 32'(proj_y), 32'd2);
    step(1, 0, 0, 10'd300, 10'd50);
    check("flfire_x", 32'(proj_x), 32'd10);
    check("flfire_y", 32'(proj_y), 32'd2);
    check("flfire_active", 32'(proj_active), 32'd1);
    check("flfire_nohit", 32'(hit | miss), 32'd0);
    step(0, 1, 0, 10'd0, 10'd0);
    check("miss_pulse", 32'(miss), 32'd1);
    check("miss_nohit", 32'(hit), 32'd0);
    check("miss_active", 32'(proj_active), 32'd0);
    check("miss_y", 32'(proj_y), 32'd2);
    step(0, 0, 1, 10'd0, 10'd0);
    check("miss_end", 32'(miss), 32'd0);
    check("cdcoll_nohit", 32'(hit), 32'd0);
    step(0, 1, 0, 10'd0, 10'd0);
    step(0, 1, 0, 10'd0, 10'd0);
    check("miss_cd_ready", 32'(ready), 32'd1);

    // Collision coincident with a tick
    step(1, 0, 0, 10'd50, 10'd200);
    step(0, 1, 1, 10'd0, 10'd0);
    check("colltick_hit", 32'(hit), 32'd1);
    check("colltick_y", 32'(proj_y), 32'd200);
    step(0, 1, 0, 10'd0, 10'd0);
    step(0, 1, 0, 10'd0, 10'd0);
    check("colltick_ready", 32'(ready), 32'd1);

    // Asynchronous reset mid-flight, then a normal launch
    step(1, 0, 0, 10'd20, 10'd304);
    step(0, 1, 0, 10'd0, 10'd0);
    check("pre_rst_y", 32'(proj_y), 32'd300);
    #2 rst = 1'b0;
    #1 check_reset_vals("arst");
    @(posedge clk); #1;
    check_reset_vals("arst_hold");
    rst = 1'b1;
    step(1, 0, 0, 10'd100, 10'd400);
    check("relaunch_active", 32'(proj_active), 32'd1);
    check("relaunch_x", 32'(proj_x), 32'd100);
    check("relaunch_y", 32'(proj_y), 32'd400);
    check("relaunch_ready", 32'(ready), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
